rsa_modexp_ctrl: RTL and testbench
==================================

Name: rsa_modexp_ctrl

Overview:
Modular-exponentiation sequencer for the RSA datapath. It computes base^exponent mod modulus with right-to-left square-and-multiply. It does no arithmetic of its own: it acts as the initiator of the Montgomery-multiplier valid/ready request interface and the consumer of its result interface, with one multiplication outstanding at a time. It sits between the RSA top-level command path and a single Montgomery multiplier instance.

Parameters:
MOD_WIDTH, 256, operand/modulus width in bits; the Montgomery radix is R = 2^MOD_WIDTH.

Ports:
clk  input  1  clock, all logic on posedge
rst  input  1  synchronous, active-high reset
i_valid  input  1  job request
i_ready  output  1  high only in IDLE
i_base  input  MOD_WIDTH  base, < i_modulus
i_exponent  input  MOD_WIDTH  exponent
i_modulus  input  MOD_WIDTH  odd modulus N
i_r2  input  MOD_WIDTH  R^2 mod N, precomputed by the caller
m_valid  output  1  multiplier request valid
m_ready  input  1  multiplier request ready
m_a  output  MOD_WIDTH  multiplicand
m_b  output  MOD_WIDTH  multiplier
m_modulus  output  MOD_WIDTH  registered copy of N
s_valid  input  1  multiplier result valid
s_ready  output  1  result ready
s_out  input  MOD_WIDTH  multiplier result
o_valid  output  1  job result valid
o_ready  input  1  job result accepted
o_out  output  MOD_WIDTH  base^exponent mod N, fully reduced

Behaviour:
- Reset (synchronous, rst=1 at posedge): state=IDLE. i_ready=1. m_valid=0, s_ready=0, o_valid=0. o_out, m_a, m_b, m_modulus and internal registers=0.
- rst dominates every other input, including in mid-job. The multiplier shares clk/rst, so no stale result is pending after reset.
- Job accept: i_valid&&i_ready latches base, exponent, modulus and r2, and sets op=OP_BASE. IDLE->ISSUE.
- Operation sequence (Mont(x,y) = x*y*R^-1 mod N):
  - OP_BASE: bm = Mont(base, r2).
  - OP_ONE: acc = Mont(1, r2).
  - Loop over exponent bits 0..MOD_WIDTH-1, LSB first:
    - OP_MUL (only if the current bit is 1): acc = Mont(acc, bm).
    - OP_SQR: bm = Mont(bm, bm).
  - OP_FINAL: res = Mont(acc, 1).
- States:
  - IDLE: waits for a job.
  - ISSUE: m_valid=1 with the operands for the current op. Moves to WAIT on the m_valid&&m_ready cycle.
  - WAIT: s_ready=1. On s_valid&&s_ready, writes s_out to the op's destination, then selects the next op:
    - Next op is OP_FINAL -> DONE.
    - Otherwise -> ISSUE.
  - DONE: o_valid=1. Moves to IDLE when o_ready=1.
- Handshake rules:
  - m_a, m_b and m_modulus are registered and stay stable while m_valid=1 and m_ready=0.
  - m_valid never drops without the handshake completing.
  - Request-to-result latency is whatever the multiplier takes; the sequencer tolerates any number of wait cycles.
  - At most one request is outstanding.
  - s_ready=0 outside WAIT.
- Bit index:
  - Bit counter width is $clog2(MOD_WIDTH+1). It increments after each OP_SQR.
  - The loop ends when the counter reaches MOD_WIDTH. No wrap.
- Reduction:
  - Multiplier results may be in [0, 2N).
  - Intermediate values go back to the multiplier unreduced.
  - At OP_FINAL capture: o_out = (s_out >= N) ? s_out - N : s_out, using a MOD_WIDTH+1-bit compare/subtract.
- o_out holds its value from the DONE entry until the next job's OP_FINAL capture.
- Boundaries:
  - exponent=0 -> result 1 mod N.
  - base=0 with exponent>0 -> 0.
  - o_ready held high -> DONE lasts exactly 1 cycle; IDLE is entered on the next cycle.
  - i_valid is ignored outside IDLE.
- Request count, baseline: 2 + MOD_WIDTH + popcount(exponent) + 1.

Optional Feature:
RSA_MODEXP_EARLY_EXIT_EN
- Defined:
  - After the current bit's OP_MUL slot, if (remaining exponent >> 1) == 0, skip OP_SQR and go straight to OP_FINAL.
  - Consequence: exponent=0 jumps from OP_ONE directly to OP_FINAL.
  - Request count = 2 + popcount + squarings up to the MSB set bit + 1.
  - The result is identical to the baseline.
- Undefined: all MOD_WIDTH squarings always run.

Test Plan:
- Basic job. Setup: MOD_WIDTH=8, N=13, r2=3, base=2, exponent=5, behavioural multiplier with 0-cycle ready and 3-cycle result. Required: o_out=6. Request count: 13 baseline, 7 with EARLY_EXIT_EN.
- Zero exponent. Same setup, exponent=0. Required: o_out=1. Request count: 11 baseline, 3 with EN.
- Zero base. base=0, exponent=7. Required: o_out=0.
- Backpressure. Randomly deassert m_ready and s_valid, and hold o_ready=0 for 10 cycles at DONE. Required: m_a/m_b stable while stalled; o_valid held; o_out=6; i_ready=0 throughout.
- Mid-job reset. Assert rst during the 5th WAIT. Required next cycle: IDLE, i_ready=1, m_valid=0, o_valid=0. A new job with base=3, exponent=3 then gives o_out=1 (27 mod 13).
- Back-to-back jobs with o_ready=1. Required: o_valid pulses for exactly 1 cycle per job, and i_ready rises the cycle after.

Source files
------------

// File: rtl/rsa_modexp_ctrl.sv
// rsa_modexp_ctrl: right-to-left square-and-multiply sequencer driving one Montgomery multiplier.
// Optional build macro RSA_MODEXP_EARLY_EXIT_EN stops squaring once no higher exponent bits remain.
module rsa_modexp_ctrl #(
  parameter int MOD_WIDTH = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  output logic                 i_ready,
  input  logic [MOD_WIDTH-1:0] i_base,
  input  logic [MOD_WIDTH-1:0] i_exponent,
  input  logic [MOD_WIDTH-1:0] i_modulus,
  input  logic [MOD_WIDTH-1:0] i_r2,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [MOD_WIDTH-1:0] m_a,
  output logic [MOD_WIDTH-1:0] m_b,
  output logic [MOD_WIDTH-1:0] m_modulus,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [MOD_WIDTH-1:0] s_out,
  output logic                 o_valid,
  input  logic                 o_ready,
  output logic [MOD_WIDTH-1:0] o_out
);

  localparam int CW = $clog2(MOD_WIDTH + 1);
  localparam logic [MOD_WIDTH-1:0] ONE = {{(MOD_WIDTH-1){1'b0}}, 1'b1};

`ifdef RSA_MODEXP_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  typedef enum logic [2:0] {OP_BASE, OP_ONE, OP_MUL, OP_SQR, OP_FINAL} op_t;

  state_t state, state_nxt;
  op_t    op, op_nxt;

  logic [MOD_WIDTH-1:0] base_q, exp_q, r2_q, acc_q, bm_q;
  logic [MOD_WIDTH-1:0] acc_nxt, bm_nxt, a_nxt, b_nxt;
  logic [MOD_WIDTH-1:0] rem, rem_next;
  logic [CW-1:0]        cnt, cnt_inc, cnt_nxt;
  logic [MOD_WIDTH:0]   diff;
  logic                 accept, s_fire;

  assign accept   = (state == IDLE) && i_valid;
  assign s_fire   = (state == WAIT) && s_valid;
  assign cnt_inc  = cnt + 1'b1;
  assign rem      = exp_q >> cnt;
  assign rem_next = exp_q >> cnt_inc;
  assign diff     = {1'b0, s_out} - {1'b0, m_modulus};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    i_ready   = 1'b0;
    m_valid   = 1'b0;
    s_ready   = 1'b0;
    o_valid   = 1'b0;
    case (state)
      IDLE: begin
        i_ready = 1'b1;
        if (i_valid) state_nxt = ISSUE;
      end
      ISSUE: begin
        m_valid = 1'b1;
        if (m_ready) state_nxt = WAIT;
      end
      WAIT: begin
        s_ready = 1'b1;
        if (s_valid) state_nxt = (op == OP_FINAL) ? DONE : ISSUE;
      end
      default: begin
        o_valid = 1'b1;
        if (o_ready) state_nxt = IDLE;
      end
    endcase
  end

  // Result write-back for the finishing op and choice of the op that follows it.
  always_comb begin
    acc_nxt = acc_q;
    bm_nxt  = bm_q;
    op_nxt  = op;
    cnt_nxt = cnt;
    case (op)
      OP_BASE: begin
        bm_nxt = s_out;
        op_nxt = OP_ONE;
      end
      OP_ONE: begin
        acc_nxt = s_out;
        if (EARLY_EXIT && (exp_q == '0)) op_nxt = OP_FINAL;
        else if (exp_q[0])               op_nxt = OP_MUL;
        else                             op_nxt = OP_SQR;
      end
      OP_MUL: begin
        acc_nxt = s_out;
        if (EARLY_EXIT && ((rem >> 1) == '0)) op_nxt = OP_FINAL;
        else                                  op_nxt = OP_SQR;
      end
      OP_SQR: begin
        bm_nxt  = s_out;
        cnt_nxt = cnt_inc;
        if (cnt_inc == CW'(MOD_WIDTH))                  op_nxt = OP_FINAL;
        else if (rem_next[0])                           op_nxt = OP_MUL;
        else if (EARLY_EXIT && ((rem_next >> 1) == '0)) op_nxt = OP_FINAL;
        else                                            op_nxt = OP_SQR;
      end
      default: op_nxt = OP_FINAL;
    endcase
  end

  // Operands use the forwarded accumulator/base so the register written this cycle is seen.
  always_comb begin
    a_nxt = base_q;
    b_nxt = r2_q;
    case (op_nxt)
      OP_ONE: begin
        a_nxt = ONE;
        b_nxt = r2_q;
      end
      OP_MUL: begin
        a_nxt = acc_nxt;
        b_nxt = bm_nxt;
      end
      OP_SQR: begin
        a_nxt = bm_nxt;
        b_nxt = bm_nxt;
      end
      OP_FINAL: begin
        a_nxt = acc_nxt;
        b_nxt = ONE;
      end
      default: begin
        a_nxt = base_q;
        b_nxt = r2_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base_q    <= '0;
      exp_q     <= '0;
      r2_q      <= '0;
      acc_q     <= '0;
      bm_q      <= '0;
      cnt       <= '0;
      op        <= OP_BASE;
      m_a       <= '0;
      m_b       <= '0;
      m_modulus <= '0;
      o_out     <= '0;
    end else if (accept) begin
      base_q    <= i_base;
      exp_q     <= i_exponent;
      r2_q      <= i_r2;
      acc_q     <= '0;
      bm_q      <= '0;
      cnt       <= '0;
      op        <= OP_BASE;
      m_a       <= i_base;
      m_b       <= i_r2;
      m_modulus <= i_modulus;
    end else if (s_fire) begin
      if (op == OP_FINAL) begin
        // Multiplier output lies in [0, 2N); one conditional subtract fully reduces it.
        o_out <= diff[MOD_WIDTH] ? s_out : diff[MOD_WIDTH-1:0];
      end else begin
        acc_q <= acc_nxt;
        bm_q  <= bm_nxt;
        cnt   <= cnt_nxt;
        op    <= op_nxt;
        m_a   <= a_nxt;
        m_b   <= b_nxt;
      end
    end
  end

endmodule

// File: tb/tb_rsa_modexp_ctrl.sv
// Self-checking bench for rsa_modexp_ctrl: table-driven jobs, directed corner cases and random jobs
// against a behavioural Montgomery multiplier and a plain modular-power reference.
module tb_rsa_modexp_ctrl;

  localparam int W = 8;

`ifdef RSA_MODEXP_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic         clk;
  logic         rst;
  logic         i_valid;
  logic         i_ready;
  logic [W-1:0] i_base;
  logic [W-1:0] i_exponent;
  logic [W-1:0] i_modulus;
  logic [W-1:0] i_r2;
  logic         m_valid;
  logic         m_ready;
  logic [W-1:0] m_a;
  logic [W-1:0] m_b;
  logic [W-1:0] m_modulus;
  logic         s_valid;
  logic         s_ready;
  logic [W-1:0] s_out;
  logic         o_valid;
  logic         o_ready;
  logic [W-1:0] o_out;

  rsa_modexp_ctrl #(.MOD_WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_valid   (i_valid),
    .i_ready   (i_ready),
    .i_base    (i_base),
    .i_exponent(i_exponent),
    .i_modulus (i_modulus),
    .i_r2      (i_r2),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_a       (m_a),
    .m_b       (m_b),
    .m_modulus (m_modulus),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_out     (s_out),
    .o_valid   (o_valid),
    .o_ready   (o_ready),
    .o_out     (o_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int passes;
  int cur_n;
  int cur_rinv;
  int req_count;
  int lat_min;
  int lat_max;
  bit rand_bp;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual == expected) passes++;
    else $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Inverse of R = 2^W modulo n, found by search.
  function automatic int mod_inv_r(input int n);
    for (int k = 1; k < n; k++)
      if (((256 * k) % n) == 1) return k;
    return 0;
  endfunction

  function automatic int mod_pow(input int b, input int e, input int n);
    int r;
    r = 1 % n;
    for (int i = 0; i < e; i++) r = (r * b) % n;
    return r;
  endfunction

  function automatic int expected_reqs(input int e);
    int pc;
    int msb;
    pc  = 0;
    msb = 0;
    for (int i = 0; i < W; i++)
      if (e[i]) begin
        pc++;
        msb = i;
      end
    return EARLY ? (2 + pc + msb + 1) : (2 + W + pc + 1);
  endfunction

  // Montgomery product, sometimes left in [N, 2N) to exercise the final reduction.
  function automatic int mont(input int x, input int y);
    int r;
    r = (x * y * cur_rinv) % cur_n;
    if (($urandom_range(1, 0) == 1) && (r + cur_n < 256)) r = r + cur_n;
    return r;
  endfunction

  // Behavioural multiplier: acts on the handshakes seen at the preceding posedge.
  bit           pend;
  int           delay;
  int           res;
  bit           p_mv, p_mr, p_sv, p_sr;
  logic [W-1:0] p_a, p_b;

  initial begin : mult_model
    pend = 0; delay = 0; res = 0;
    p_mv = 0; p_mr = 0; p_sv = 0; p_sr = 0; p_a = '0; p_b = '0;
    m_ready = 1'b0;
    s_valid = 1'b0;
    s_out   = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend    = 0;
        delay   = 0;
        s_valid = 1'b0;
      end else begin
        if (p_sv && p_sr) begin
          pend    = 0;
          s_valid = 1'b0;
        end
        if (p_mv && p_mr) begin
          checkOutput("one_outstanding", pend, 0);
          pend  = 1;
          res   = mont(int'(p_a), int'(p_b));
          delay = $urandom_range(lat_max, lat_min);
          req_count++;
        end else if (p_mv) begin
          checkOutput("req_stable", {m_valid, m_a, m_b}, {1'b1, p_a, p_b});
        end
      end
      m_ready = rand_bp ? ($urandom_range(1, 0) == 1) : 1'b1;
      if (pend && !s_valid) begin
        if (delay > 0) delay--;
        else if (!rand_bp || ($urandom_range(1, 0) == 1)) begin
          s_valid = 1'b1;
          s_out   = W'(res);
        end
      end
      p_mv = m_valid; p_mr = m_ready; p_a = m_a; p_b = m_b;
      p_sv = s_valid; p_sr = s_ready;
    end
  end

  // Runs one job from IDLE; hold = cycles o_ready stays low once o_valid appears.
  task automatic applyStimulus(input int b, input int e, input int n, input int r2, input int hold,
                               output int got, output int reqs, output bit busy_ok,
                               output bit hold_ok, output bit exit_ok, output bit to);
    int cyc;
    cur_n     = n;
    cur_rinv  = mod_inv_r(n);
    req_count = 0;
    busy_ok   = 1; hold_ok = 1; exit_ok = 0; to = 0; got = -1;
    o_ready    = (hold == 0);
    i_base     = W'(b);
    i_exponent = W'(e);
    i_modulus  = W'(n);
    i_r2       = W'(r2);
    i_valid    = 1'b1;
    tick();
    checkOutput("m_modulus", m_modulus, n);
    cyc = 0;
    while (!o_valid && cyc < 5000) begin
      if (i_ready) busy_ok = 0;
      i_valid    = rand_bp ? ($urandom_range(1, 0) == 1) : 1'b0;
      i_base     = W'($urandom);
      i_exponent = W'($urandom);
      i_modulus  = W'($urandom);
      tick();
      cyc++;
    end
    i_valid = 1'b0;
    if (!o_valid) begin
      to      = 1;
      reqs    = req_count;
      rst     = 1'b1;
      tick();
      rst     = 1'b0;
      o_ready = 1'b1;
      return;
    end
    got = int'(o_out);
    for (int k = 0; k < hold; k++) begin
      tick();
      if (!o_valid || (int'(o_out) != got) || i_ready) hold_ok = 0;
    end
    o_ready = 1'b1;
    tick();
    exit_ok = !o_valid && i_ready && (int'(o_out) == got);
    reqs    = req_count;
  endtask

  typedef struct {
    int base;
    int e;
    int n;
    int r2;
    int want;
    int reqs_base;
    int reqs_early;
  } vec_t;

  vec_t vecs[8];
  int   got, reqs, waits, n, b, e, hold;
  bit   busy_ok, hold_ok, exit_ok, to, prev_sr;

  initial begin
    vecs[0] = '{2, 5,   13, 3, 6,  13, 7};
    vecs[1] = '{2, 0,   13, 3, 1,  11, 3};
    vecs[2] = '{0, 7,   13, 3, 0,  14, 8};
    vecs[3] = '{3, 3,   13, 3, 1,  13, 6};
    vecs[4] = '{5, 8,   13, 3, 1,  12, 7};
    vecs[5] = '{12, 255, 13, 3, 12, 19, 18};
    vecs[6] = '{10, 1,  13, 3, 10, 12, 4};
    vecs[7] = '{4, 2,   7,  2, 2,  12, 5};

    checks = 0; passes = 0;
    cur_n = 13; cur_rinv = 3; req_count = 0;
    lat_min = 3; lat_max = 3; rand_bp = 0;
    rst = 1'b1; i_valid = 1'b0; o_ready = 1'b1;
    i_base = '0; i_exponent = '0; i_modulus = '0; i_r2 = '0;
    repeat (3) tick();
    checkOutput("rst_i_ready", i_ready, 1);
    checkOutput("rst_m_valid", m_valid, 0);
    checkOutput("rst_s_ready", s_ready, 0);
    checkOutput("rst_o_valid", o_valid, 0);
    checkOutput("rst_regs", {o_out, m_a, m_b, m_modulus}, 0);
    rst = 1'b0;
    tick();

    // Back-to-back table jobs with o_ready held high.
    for (int v = 0; v < 8; v++) begin
      applyStimulus(vecs[v].base, vecs[v].e, vecs[v].n, vecs[v].r2, 0,
                    got, reqs, busy_ok, hold_ok, exit_ok, to);
      checkOutput($sformatf("vec%0d_timeout", v), to, 0);
      checkOutput($sformatf("vec%0d_out", v), got, vecs[v].want);
      checkOutput($sformatf("vec%0d_reqs", v), reqs, EARLY ? vecs[v].reqs_early : vecs[v].reqs_base);
      checkOutput($sformatf("vec%0d_busy_i_ready", v), busy_ok, 1);
      checkOutput($sformatf("vec%0d_done_one_cycle", v), exit_ok, 1);
    end

    // Backpressure on both multiplier channels and a 10-cycle hold at DONE.
    rand_bp = 1; lat_min = 0; lat_max = 4;
    applyStimulus(2, 5, 13, 3, 10, got, reqs, busy_ok, hold_ok, exit_ok, to);
    checkOutput("bp_timeout", to, 0);
    checkOutput("bp_out", got, 6);
    checkOutput("bp_busy_i_ready", busy_ok, 1);
    checkOutput("bp_done_held", hold_ok, 1);
    checkOutput("bp_exit", exit_ok, 1);
    rand_bp = 0; lat_min = 3; lat_max = 3;

    // Reset in the middle of the fifth WAIT, then a fresh job.
    cur_n = 13; cur_rinv = 3;
    i_base = 2; i_exponent = 5; i_modulus = 13; i_r2 = 3; i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    waits = 0; prev_sr = 0;
    for (int cyc = 0; cyc < 2000 && waits < 5; cyc++) begin
      if (s_ready && !prev_sr) waits++;
      prev_sr = s_ready;
      if (waits < 5) tick();
    end
    checkOutput("reached_5th_wait", waits, 5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("midrst_i_ready", i_ready, 1);
    checkOutput("midrst_m_valid", m_valid, 0);
    checkOutput("midrst_o_valid", o_valid, 0);
    checkOutput("midrst_s_ready", s_ready, 0);
    applyStimulus(3, 3, 13, 3, 0, got, reqs, busy_ok, hold_ok, exit_ok, to);
    checkOutput("midrst_job_out", got, 1);
    checkOutput("midrst_job_reqs", reqs, expected_reqs(3));

    // Random jobs against the arithmetic reference.
    for (int j = 0; j < 25; j++) begin
      rand_bp = ($urandom_range(1, 0) == 1);
      lat_min = 0;
      lat_max = $urandom_range(4, 0);
      n       = 2 * $urandom_range(63, 1) + 1;
      b       = $urandom_range(n - 1, 0);
      e       = (j % 6 == 0) ? 0 : $urandom_range(255, 0);
      hold    = $urandom_range(3, 0);
      applyStimulus(b, e, n, 65536 % n, hold, got, reqs, busy_ok, hold_ok, exit_ok, to);
      checkOutput($sformatf("rnd%0d_timeout", j), to, 0);
      checkOutput($sformatf("rnd%0d_out(b=%0d e=%0d n=%0d)", j, b, e, n), got, mod_pow(b, e, n));
      checkOutput($sformatf("rnd%0d_reqs", j), reqs, expected_reqs(e));
      checkOutput($sformatf("rnd%0d_busy_i_ready", j), busy_ok, 1);
      checkOutput($sformatf("rnd%0d_hold", j), hold_ok, 1);
      checkOutput($sformatf("rnd%0d_exit", j), exit_ok, 1);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
